// File: rtl/slot_memctl.sv
// Request/acknowledge sequencer between the Z88 bus and NSLOTS byte-wide slot memories.
// Define SLOT_MEMCTL_WAITCFG_EN to add the per-slot ACCESS length input wait_cfg.
module slot_memctl #(
    parameter int                NSLOTS   = 4,
    parameter int                ADDR_W   = 22,
    parameter int                SLOT_AW  = 19,
    parameter int                WAIT_CYC = 2,
    parameter logic [NSLOTS-1:0] WP_MASK  = {{(NSLOTS-1){1'b0}}, 1'b1}
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req,
    input  logic                  req_wr,
    input  logic [ADDR_W-1:0]     req_a,
    input  logic [7:0]            req_do,
    output logic                  ack,
    output logic [7:0]            rd_data,
    output logic                  wp_err,
    input  logic [NSLOTS-1:0]     slot_present,
    output logic [SLOT_AW-1:0]    mem_a,
    output logic [7:0]            mem_di,
    input  logic [8*NSLOTS-1:0]   mem_do,
    output logic [NSLOTS-1:0]     mem_ce_n,
    output logic                  mem_oe_n,
    output logic                  mem_we_n,
`ifdef SLOT_MEMCTL_WAITCFG_EN
    input  logic [4*NSLOTS-1:0]   wait_cfg,
`endif
    output logic                  busy,
    output logic [1:0]            dbg_state
);

    // Handshake: req/req_wr/req_a/req_do are sampled only while busy is low (IDLE);
    // ack pulses for exactly one cycle in DONE, and a req held high through ack is
    // taken again in the IDLE cycle that follows DONE.

    localparam int         SLOT_W  = $clog2(NSLOTS);
    localparam logic [3:0] WAIT_M1 = 4'(WAIT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                wr_q, wr_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [3:0]          len_m1_q, len_m1_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                ack_q, ack_d;
    logic                wp_err_q, wp_err_d;
    logic                busy_q, busy_d;
    logic [7:0]          rd_data_q, rd_data_d;
    logic [SLOT_AW-1:0]  mem_a_q, mem_a_d;
    logic [7:0]          mem_di_q, mem_di_d;
    logic [NSLOTS-1:0]   ce_n_q, ce_n_d;
    logic                oe_n_q, oe_n_d;
    logic                we_n_q, we_n_d;

    logic [SLOT_W-1:0]   req_slot;
    logic                req_bypass;
    logic [3:0]          req_len_m1;
    logic                unused_ok;

    assign req_slot   = req_a[ADDR_W-1 -: SLOT_W];
    assign req_bypass = !slot_present[req_slot] || (req_wr && WP_MASK[req_slot]);
    assign unused_ok  = ^req_a;

`ifdef SLOT_MEMCTL_WAITCFG_EN
    logic [3:0] cfg_nib;
    assign cfg_nib    = wait_cfg[4*req_slot +: 4];
    // A zero nibble still needs one ACCESS cycle.
    assign req_len_m1 = (cfg_nib == 4'd0) ? 4'd0 : cfg_nib - 4'd1;
`else
    assign req_len_m1 = WAIT_M1;
`endif

    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        slot_d    = slot_q;
        len_m1_d  = len_m1_q;
        cnt_d     = cnt_q;
        ack_d     = 1'b0;
        wp_err_d  = 1'b0;
        busy_d    = busy_q;
        rd_data_d = rd_data_q;
        mem_a_d   = mem_a_q;
        mem_di_d  = mem_di_q;
        ce_n_d    = ce_n_q;
        oe_n_d    = oe_n_q;
        we_n_d    = we_n_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    wr_d     = req_wr;
                    slot_d   = req_slot;
                    len_m1_d = req_len_m1;
                    busy_d   = 1'b1;
                    if (req_bypass) begin
                        // Absent slot or protected write: complete without touching the bus.
                        state_d  = S_DONE;
                        ack_d    = 1'b1;
                        wp_err_d = req_wr & slot_present[req_slot];
                        if (!req_wr) begin
                            rd_data_d = 8'hFF;
                        end
                    end else begin
                        state_d          = S_SETUP;
                        mem_a_d          = req_a[SLOT_AW-1:0];
                        mem_di_d         = req_do;
                        ce_n_d           = '1;
                        ce_n_d[req_slot] = 1'b0;
                        oe_n_d           = req_wr;
                    end
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
                cnt_d   = len_m1_q;
                we_n_d  = ~wr_q;
            end
            S_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                    ack_d   = 1'b1;
                    ce_n_d  = '1;
                    oe_n_d  = 1'b1;
                    we_n_d  = 1'b1;
                    if (!wr_q) begin
                        rd_data_d = mem_do[8*slot_q +: 8];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            wr_q      <= 1'b0;
            slot_q    <= '0;
            len_m1_q  <= '0;
            cnt_q     <= '0;
            ack_q     <= 1'b0;
            wp_err_q  <= 1'b0;
            busy_q    <= 1'b0;
            rd_data_q <= 8'hFF;
            mem_a_q   <= '0;
            mem_di_q  <= '0;
            ce_n_q    <= '1;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            slot_q    <= slot_d;
            len_m1_q  <= len_m1_d;
            cnt_q     <= cnt_d;
            ack_q     <= ack_d;
            wp_err_q  <= wp_err_d;
            busy_q    <= busy_d;
            rd_data_q <= rd_data_d;
            mem_a_q   <= mem_a_d;
            mem_di_q  <= mem_di_d;
            ce_n_q    <= ce_n_d;
            oe_n_q    <= oe_n_d;
            we_n_q    <= we_n_d;
        end
    end

    assign ack       = ack_q;
    assign wp_err    = wp_err_q;
    assign busy      = busy_q;
    assign rd_data   = rd_data_q;
    assign mem_a     = mem_a_q;
    assign mem_di    = mem_di_q;
    assign mem_ce_n  = ce_n_q;
    assign mem_oe_n  = oe_n_q;
    assign mem_we_n  = we_n_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_slot_memctl.sv
// Bench for slot_memctl: byte-wide slot memory models, an address-image reference model,
// directed scenarios plus randomized requests. Optional wait_cfg under SLOT_MEMCTL_WAITCFG_EN.
module tb_slot_memctl;

    localparam int         NSLOTS   = 4;
    localparam int         ADDR_W   = 22;
    localparam int         SLOT_AW  = 19;
    localparam int         WAIT_CYC = 2;
    localparam logic [3:0] WP       = 4'b0001;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         req;
    logic         req_wr;
    logic [21:0]  req_a;
    logic [7:0]   req_do;
    logic         ack;
    logic [7:0]   rd_data;
    logic         wp_err;
    logic [3:0]   slot_present;
    logic [18:0]  mem_a;
    logic [7:0]   mem_di;
    logic [31:0]  mem_do;
    logic [3:0]   mem_ce_n;
    logic         mem_oe_n;
    logic         mem_we_n;
    logic         busy;
    logic [1:0]   dbg_state;
`ifdef SLOT_MEMCTL_WAITCFG_EN
    logic [15:0]  wait_cfg = 16'h3122;
`endif

    int total = 0;
    int bad   = 0;
    logic [7:0] dev_mem [int];
    logic [7:0] ref_mem [int];
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    slot_memctl #(
        .NSLOTS(NSLOTS), .ADDR_W(ADDR_W), .SLOT_AW(SLOT_AW),
        .WAIT_CYC(WAIT_CYC), .WP_MASK(WP)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_wr(req_wr), .req_a(req_a),
        .req_do(req_do), .ack(ack), .rd_data(rd_data), .wp_err(wp_err),
        .slot_present(slot_present), .mem_a(mem_a), .mem_di(mem_di), .mem_do(mem_do),
        .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n),
`ifdef SLOT_MEMCTL_WAITCFG_EN
        .wait_cfg(wait_cfg),
`endif
        .busy(busy), .dbg_state(dbg_state)
    );

    function automatic int key(int s, logic [18:0] a);
        return (s << 20) | int'(a);
    endfunction

    function automatic logic [7:0] init_byte(int s, logic [18:0] a);
        return 8'(s * 37 + int'(a) * 5 + 11);
    endfunction

    function automatic logic [7:0] dev_byte(int s, logic [18:0] a);
        return dev_mem.exists(key(s, a)) ? dev_mem[key(s, a)] : init_byte(s, a);
    endfunction

    function automatic logic [7:0] ref_byte(int s, logic [18:0] a);
        return ref_mem.exists(key(s, a)) ? ref_mem[key(s, a)] : init_byte(s, a);
    endfunction

    // Slot memories: a write lands on each clock while we_n and that slot's ce_n are low.
    always @(posedge clk or mem_a) begin
        if (!mem_we_n) begin
            for (int i = 0; i < NSLOTS; i++) begin
                if (!mem_ce_n[i]) dev_mem[key(i, mem_a)] = mem_di;
            end
        end
        for (int i = 0; i < NSLOTS; i++) mem_do[8*i +: 8] = dev_byte(i, mem_a);
    end

    // Reference rules: ACCESS length per slot and whether a request skips the bus.
    function automatic int exp_len(int s);
`ifdef SLOT_MEMCTL_WAITCFG_EN
        logic [3:0] nib;
        nib = wait_cfg[4*s +: 4];
        return (nib == 4'd0) ? 1 : int'(nib);
`else
        return WAIT_CYC;
`endif
    endfunction

    function automatic bit is_bypass(int s, bit wr, logic [3:0] pres);
        logic [3:0] wp;
        wp = WP;
        return !pres[s] || (wr && wp[s]);
    endfunction

    // Driver: issue one request from IDLE and record what the bus did until ack.
    task automatic run_req(input bit wr, input logic [21:0] a, input logic [7:0] d,
                           output int lat, output int ce_cyc, output int we_cyc,
                           output int oe_cyc, output int bad_strobe,
                           output logic [3:0] ce_seen, output logic [18:0] a_seen,
                           output logic [7:0] di_seen, output logic [7:0] rd_seen,
                           output logic wp_seen, output logic busy_seen,
                           output logic ack_after);
        ce_cyc = 0; we_cyc = 0; oe_cyc = 0; bad_strobe = 0;
        ce_seen = 4'hF; a_seen = '0; di_seen = '0;
        @(negedge clk);
        req = 1'b1; req_wr = wr; req_a = a; req_do = d;
        @(posedge clk); #1;
        req = 1'b0;
        lat = 1;
        while (!ack && lat < 40) begin
            if (mem_ce_n != 4'hF) begin
                ce_cyc++; ce_seen = mem_ce_n; a_seen = mem_a; di_seen = mem_di;
            end
            if (!mem_we_n) we_cyc++;
            if (!mem_oe_n) oe_cyc++;
            if (!mem_we_n && (!mem_oe_n || mem_ce_n == 4'hF)) bad_strobe++;
            @(posedge clk); #1;
            lat++;
        end
        if (mem_ce_n != 4'hF || !mem_oe_n || !mem_we_n) bad_strobe++;
        rd_seen = rd_data; wp_seen = wp_err; busy_seen = busy;
        @(posedge clk); #1;
        ack_after = ack;
    endtask

    int lat, ce_c, we_c, oe_c, bs;
    logic [3:0] ce_s;
    logic [18:0] a_s;
    logic [7:0] di_s, rd_s;
    logic wp_s, busy_s, ack_a;

    task automatic test_reset();
        reset_n = 1'b0; req = 1'b1; req_wr = 1'b0; req_a = '0; req_do = '0;
        slot_present = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({mem_ce_n, mem_oe_n, mem_we_n} !== 6'h3F) begin
            bad++; $display("FAIL reset_strobes: got %b want 111111", {mem_ce_n, mem_oe_n, mem_we_n});
        end
        total++;
        if ({ack, busy, wp_err, rd_data} !== {3'b000, 8'hFF}) begin
            bad++; $display("FAIL reset_status: ack/busy/wp/rd got %b%b%b/%h want 000/ff", ack, busy, wp_err, rd_data);
        end
        total++;
        if ({mem_a, mem_di} !== 27'd0) begin
            bad++; $display("FAIL reset_bus: mem_a=%h mem_di=%h want 0/0", mem_a, mem_di);
        end
        @(negedge clk);
        reset_n = 1'b1; req = 1'b0;
        dev_mem[key(0, 19'h00123)] = 8'hA5;
        ref_mem[key(0, 19'h00123)] = 8'hA5;
        run_req(1'b0, 22'h000123, 8'h00, lat, ce_c, we_c, oe_c, bs, ce_s, a_s, di_s, rd_s, wp_s, busy_s, ack_a);
        total++;
        if (lat !== exp_len(0) + 2) begin
            bad++; $display("FAIL first_read_latency: got %0d want %0d", lat, exp_len(0) + 2);
        end
        total++;
        if (rd_s !== 8'hA5) begin
            bad++; $display("FAIL first_read_data: got %h want a5", rd_s);
        end
        total++;
        if (a_s !== 19'h00123 || ce_s !== 4'b1110) begin
            bad++; $display("FAIL first_read_bus: mem_a=%h ce_n=%b want 00123/1110", a_s, ce_s);
        end
        total++;
        if (ce_c !== exp_len(0) + 1 || oe_c !== exp_len(0) + 1 || we_c !== 0 || bs !== 0) begin
            bad++; $display("FAIL first_read_strobes: ce=%0d oe=%0d we=%0d bad=%0d want %0d/%0d/0/0",
                            ce_c, oe_c, we_c, bs, exp_len(0) + 1, exp_len(0) + 1);
        end
        total++;
        if (busy_s !== 1'b1 || ack_a !== 1'b0) begin
            bad++; $display("FAIL first_read_ack_shape: busy_at_ack=%b ack_after=%b want 1/0", busy_s, ack_a);
        end
    endtask

    task automatic test_normal_write();
        slot_present = 4'hF;
        // Slot 1 is selected by req_a[21:20] = 2'b01.
        run_req(1'b1, 22'h100010, 8'h5A, lat, ce_c, we_c, oe_c, bs, ce_s, a_s, di_s, rd_s, wp_s, busy_s, ack_a);
        ref_mem[key(1, 19'h00010)] = 8'h5A;
        total++;
        if (ce_c !== exp_len(1) + 1 || we_c !== exp_len(1) || oe_c !== 0 || bs !== 0) begin
            bad++; $display("FAIL write_strobes: ce=%0d we=%0d oe=%0d bad=%0d want %0d/%0d/0/0",
                            ce_c, we_c, oe_c, bs, exp_len(1) + 1, exp_len(1));
        end
        total++;
        if (di_s !== 8'h5A || a_s !== 19'h00010 || ce_s !== 4'b1101) begin
            bad++; $display("FAIL write_bus: di=%h a=%h ce_n=%b want 5a/00010/1101", di_s, a_s, ce_s);
        end
        total++;
        if (lat !== exp_len(1) + 2 || wp_s !== 1'b0) begin
            bad++; $display("FAIL write_ack: lat=%0d wp=%b want %0d/0", lat, wp_s, exp_len(1) + 2);
        end
        total++;
        if (rd_s !== 8'hA5) begin
            bad++; $display("FAIL write_keeps_rd: got %h want a5", rd_s);
        end
        run_req(1'b0, 22'h100010, 8'h00, lat, ce_c, we_c, oe_c, bs, ce_s, a_s, di_s, rd_s, wp_s, busy_s, ack_a);
        total++;
        if (rd_s !== 8'h5A) begin
            bad++; $display("FAIL write_readback: got %h want 5a", rd_s);
        end
    endtask

    task automatic test_protected_write();
        run_req(1'b1, 22'h000123, 8'h3C, lat, ce_c, we_c, oe_c, bs, ce_s, a_s, di_s, rd_s, wp_s, busy_s, ack_a);
        total++;
        if (lat !== 1 || wp_s !== 1'b1 || ce_c !== 0 || we_c !== 0 || ack_a !== 1'b0) begin
            bad++; $display("FAIL protected_write: lat=%0d wp=%b ce=%0d we=%0d ack_after=%b want 1/1/0/0/0",
                            lat, wp_s, ce_c, we_c, ack_a);
        end
        run_req(1'b0, 22'h000123, 8'h00, lat, ce_c, we_c, oe_c, bs, ce_s, a_s, di_s, rd_s, wp_s, busy_s, ack_a);
        total++;
        if (rd_s !== 8'hA5) begin
            bad++; $display("FAIL protected_readback: got %h want a5", rd_s);
        end
    endtask

    task automatic test_absent_slot();
        slot_present = 4'b0011;
        run_req(1'b0, 22'h300040, 8'h00, lat, ce_c, we_c, oe_c, bs, ce_s, a_s, di_s, rd_s, wp_s, busy_s, ack_a);
        total++;
        if (lat !== 1 || rd_s !== 8'hFF || ce_c !== 0 || oe_c !== 0) begin
            bad++; $display("FAIL absent_read: lat=%0d rd=%h ce=%0d oe=%0d want 1/ff/0/0", lat, rd_s, ce_c, oe_c);
        end
        run_req(1'b1, 22'h300040, 8'h77, lat, ce_c, we_c, oe_c, bs, ce_s, a_s, di_s, rd_s, wp_s, busy_s, ack_a);
        total++;
        if (lat !== 1 || wp_s !== 1'b0 || ce_c !== 0 || we_c !== 0) begin
            bad++; $display("FAIL absent_write: lat=%0d wp=%b ce=%0d we=%0d want 1/0/0/0", lat, wp_s, ce_c, we_c);
        end
        slot_present = 4'hF;
    endtask

    task automatic test_async_reset();
        int acks;
        slot_present = 4'hF;
        @(negedge clk);
        req = 1'b1; req_wr = 1'b1; req_a = 22'h17FF00; req_do = 8'h99;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #2;
        total++;
        if (mem_we_n !== 1'b0) begin
            bad++; $display("FAIL async_pre_we: got %b want 0", mem_we_n);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if (mem_we_n !== 1'b1 || mem_ce_n !== 4'hF || busy !== 1'b0) begin
            bad++; $display("FAIL async_release: we_n=%b ce_n=%b busy=%b want 1/1111/0", mem_we_n, mem_ce_n, busy);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ack) acks++;
        end
        total++;
        if (acks !== 0) begin
            bad++; $display("FAIL async_no_ack: got %0d acks want 0", acks);
        end
        run_req(1'b0, 22'h200007, 8'h00, lat, ce_c, we_c, oe_c, bs, ce_s, a_s, di_s, rd_s, wp_s, busy_s, ack_a);
        total++;
        if (lat !== exp_len(2) + 2 || rd_s !== ref_byte(2, 19'h00007)) begin
            bad++; $display("FAIL async_next_req: lat=%0d rd=%h want %0d/%h", lat, rd_s, exp_len(2) + 2, ref_byte(2, 19'h00007));
        end
    endtask

    task automatic test_back_to_back();
        int n, gap, want;
        for (int c = 0; c < 2; c++) begin
            slot_present = (c == 0) ? 4'hF : 4'b0011;
            want = (c == 0) ? exp_len(2) + 3 : 2;
            @(negedge clk);
            req = 1'b1; req_wr = 1'b0; req_a = (c == 0) ? 22'h200005 : 22'h300001;
            n = 0;
            do begin
                @(posedge clk); #1; n++;
            end while (!ack && n < 50);
            gap = 0;
            do begin
                @(posedge clk); #1; gap++;
            end while (!ack && gap < 50);
            req = 1'b0;
            total++;
            if (gap !== want) begin
                bad++; $display("FAIL back_to_back_gap%0d: got %0d want %0d", c, gap, want);
            end
            total++;
            if (rd_data !== ((c == 0) ? ref_byte(2, 19'h00005) : 8'hFF)) begin
                bad++; $display("FAIL back_to_back_rd%0d: got %h", c, rd_data);
            end
            @(posedge clk); #1;
        end
        slot_present = 4'hF;
    endtask

    task automatic test_random();
        int s, len;
        bit wr, byp;
        logic [3:0] pres;
        logic [21:0] a;
        logic [7:0] d, e;
        logic [3:0] wp;
        wp = WP;
        for (int n = 0; n < 60; n++) begin
            s    = $urandom_range(0, 3);
            wr   = 1'($urandom_range(0, 1));
            pres = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            a    = {2'(s), 1'($urandom), 19'($urandom_range(0, 15))};
            d    = 8'($urandom);
            slot_present = pres;
            byp = is_bypass(s, wr, pres);
            len = exp_len(s);
            if (!wr) exp_q.push_back(byp ? 8'hFF : ref_byte(s, a[18:0]));
            else if (!byp) ref_mem[key(s, a[18:0])] = d;
            run_req(wr, a, d, lat, ce_c, we_c, oe_c, bs, ce_s, a_s, di_s, rd_s, wp_s, busy_s, ack_a);
            total++;
            if (lat !== (byp ? 1 : len + 2) || ack_a !== 1'b0) begin
                bad++; $display("FAIL rnd_latency[%0d]: got %0d ack_after=%b want %0d", n, lat, ack_a, byp ? 1 : len + 2);
            end
            total++;
            if (ce_c !== (byp ? 0 : len + 1) || we_c !== ((!byp && wr) ? len : 0) ||
                oe_c !== ((!byp && !wr) ? len + 1 : 0) || bs !== 0) begin
                bad++; $display("FAIL rnd_strobes[%0d]: ce=%0d we=%0d oe=%0d bad=%0d slot=%0d wr=%0b byp=%0b",
                                n, ce_c, we_c, oe_c, bs, s, wr, byp);
            end
            total++;
            if (wp_s !== (wr && pres[s] && wp[s])) begin
                bad++; $display("FAIL rnd_wp_err[%0d]: got %b want %b", n, wp_s, wr && pres[s] && wp[s]);
            end
            if (!wr) begin
                e = exp_q.pop_front();
                total++;
                if (rd_s !== e) begin
                    bad++; $display("FAIL rnd_rd_data[%0d]: got %h want %h slot=%0d", n, rd_s, e, s);
                end
            end
        end
        slot_present = 4'hF;
    endtask

`ifdef SLOT_MEMCTL_WAITCFG_EN
    task automatic test_waitcfg();
        wait_cfg = 16'h0F05;
        run_req(1'b0, 22'h000123, 8'h00, lat, ce_c, we_c, oe_c, bs, ce_s, a_s, di_s, rd_s, wp_s, busy_s, ack_a);
        total++;
        if (lat !== 7 || rd_s !== 8'hA5) begin
            bad++; $display("FAIL waitcfg_slot0: lat=%0d rd=%h want 7/a5", lat, rd_s);
        end
        run_req(1'b0, 22'h100010, 8'h00, lat, ce_c, we_c, oe_c, bs, ce_s, a_s, di_s, rd_s, wp_s, busy_s, ack_a);
        total++;
        if (lat !== 17 || rd_s !== 8'h5A) begin
            bad++; $display("FAIL waitcfg_slot1: lat=%0d rd=%h want 17/5a", lat, rd_s);
        end
        wait_cfg = 16'h0F00;
        run_req(1'b0, 22'h000123, 8'h00, lat, ce_c, we_c, oe_c, bs, ce_s, a_s, di_s, rd_s, wp_s, busy_s, ack_a);
        total++;
        if (lat !== 3) begin
            bad++; $display("FAIL waitcfg_zero: lat=%0d want 3", lat);
        end
        wait_cfg = 16'h3122;
    endtask
`endif

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_normal_write();
        test_protected_write();
        test_absent_slot();
        test_async_reset();
        test_back_to_back();
        test_random();
`ifdef SLOT_MEMCTL_WAITCFG_EN
        test_waitcfg();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
